// File: rtl/pipe_ctrl_sequencer_pkg.sv
// Shared pipeline-control definitions: FSM state encodings, 5-bit RV32I opcode fields
// and the register-usage decode helpers for the stall/flush sequencer.
package pipe_ctrl_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } pipe_state_e;

  localparam logic [4:0] OPC_LOAD_5      = 5'b00000;
  localparam logic [4:0] OPC_STORE_5     = 5'b01000;
  localparam logic [4:0] OPC_BRANCH_5    = 5'b11000;
  localparam logic [4:0] OPC_LUI_5       = 5'b01101;
  localparam logic [4:0] OPC_AUIPC_5     = 5'b00101;
  localparam logic [4:0] OPC_JAL_5       = 5'b11011;
  localparam logic [4:0] OPC_ARI_RTYPE_5 = 5'b01100;

  function automatic logic uses_rs1(input logic [4:0] opc);
    return !(opc == OPC_LUI_5 || opc == OPC_AUIPC_5 || opc == OPC_JAL_5);
  endfunction

  function automatic logic uses_rs2(input logic [4:0] opc);
    return (opc == OPC_BRANCH_5 || opc == OPC_STORE_5 || opc == OPC_ARI_RTYPE_5);
  endfunction

endpackage

// File: rtl/pipe_ctrl_sequencer_if.sv
// Bundle between the core datapath (master) and the stall/flush sequencer (slave).
interface pipe_ctrl_sequencer_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      d_instr;
  logic [31:0]      x_instr;
  logic             x_redirect;
  logic             mem_busy;
  logic             cnt_clr;
  logic             stall_f;
  logic             stall_d;
  logic             bubble_x;
  logic             freeze_x;
  logic             flush_d;
  logic             redirect_valid;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport slave (
    input  d_instr, x_instr, x_redirect, mem_busy, cnt_clr,
    output stall_f, stall_d, bubble_x, freeze_x, flush_d, redirect_valid,
           state, stall_cycles, flush_count
  );

  modport master (
    output d_instr, x_instr, x_redirect, mem_busy, cnt_clr,
    input  stall_f, stall_d, bubble_x, freeze_x, flush_d, redirect_valid,
           state, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_ctrl_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  logic [W-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && (r_q != '1)) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign q = r_q;
endmodule

// File: rtl/pipe_ctrl_sequencer.sv
// Stall/flush sequencer for the 3-stage core: arbitrates memory waits, redirects and
// load-use hazards into freeze/bubble/kill controls and keeps stall/flush counters.
module pipe_ctrl_sequencer
  import pipe_ctrl_sequencer_pkg::*;
#(
  parameter int REDIRECT_CYCLES = 2,
  parameter int CNT_W           = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  pipe_ctrl_sequencer_if.slave  bus
);
  localparam logic [2:0] FLUSH_LOAD = 3'(REDIRECT_CYCLES - 1);

  pipe_state_e r_state;
  pipe_state_e r_saved;
  logic [2:0]  r_fcnt;

  pipe_state_e w_resume;
  pipe_state_e w_next_state;
  pipe_state_e w_next_saved;
  logic [2:0]  w_next_fcnt;
  logic        w_load_use;
  logic        w_stall_f;
  logic        w_stall_d;
  logic        w_bubble_x;
  logic        w_freeze_x;
  logic        w_flush_d;
  logic        w_redirect;
  logic        w_flush_inc;
  logic [4:0]  w_x_rd;
  logic [4:0]  w_d_opc;

  // A finished memory wait resumes whatever was interrupted, with no dead cycle.
  always_comb begin
    case (r_state)
      ST_MEM_WAIT: w_resume = r_saved;
      ST_FLUSH:    w_resume = ST_FLUSH;
      default:     w_resume = ST_RUN;
    endcase
  end

  assign w_x_rd     = bus.x_instr[11:7];
  assign w_d_opc    = bus.d_instr[6:2];
  assign w_load_use = (bus.x_instr[6:2] == OPC_LOAD_5) && (w_x_rd != 5'd0) &&
                      ((uses_rs1(w_d_opc) && (bus.d_instr[19:15] == w_x_rd)) ||
                       (uses_rs2(w_d_opc) && (bus.d_instr[24:20] == w_x_rd)));

  always_comb begin
    w_stall_f    = 1'b0;
    w_stall_d    = 1'b0;
    w_bubble_x   = 1'b0;
    w_freeze_x   = 1'b0;
    w_flush_d    = 1'b0;
    w_redirect   = 1'b0;
    w_flush_inc  = 1'b0;
    w_next_state = w_resume;
    w_next_saved = r_saved;
    w_next_fcnt  = r_fcnt;
    if (bus.mem_busy) begin
      w_stall_f    = 1'b1;
      w_stall_d    = 1'b1;
      w_freeze_x   = 1'b1;
      w_next_state = ST_MEM_WAIT;
      w_next_saved = w_resume;
    end else if (w_resume == ST_FLUSH) begin
      // Redirects are ignored here: X only holds killed NOPs during the window.
      w_flush_d = 1'b1;
      if (r_fcnt <= 3'd1) begin
        w_next_fcnt  = 3'd0;
        w_next_state = ST_RUN;
      end else begin
        w_next_fcnt  = r_fcnt - 3'd1;
        w_next_state = ST_FLUSH;
      end
    end else if (bus.x_redirect) begin
      w_redirect   = 1'b1;
      w_flush_d    = 1'b1;
      w_flush_inc  = 1'b1;
      w_next_fcnt  = FLUSH_LOAD;
      w_next_state = (FLUSH_LOAD == 3'd0) ? ST_RUN : ST_FLUSH;
    end else if (w_load_use) begin
      w_stall_f  = 1'b1;
      w_stall_d  = 1'b1;
      w_bubble_x = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_saved <= ST_RUN;
      r_fcnt  <= 3'd0;
    end else begin
      r_state <= w_next_state;
      r_saved <= w_next_saved;
      r_fcnt  <= w_next_fcnt;
    end
  end

  assign bus.stall_f        = w_stall_f;
  assign bus.stall_d        = w_stall_d;
  assign bus.bubble_x       = w_bubble_x;
  assign bus.freeze_x       = w_freeze_x;
  assign bus.flush_d        = w_flush_d;
  assign bus.redirect_valid = w_redirect;
  assign bus.state          = r_state;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (bus.cnt_clr),
    .inc (w_stall_f),
    .q   (bus.stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .clr (bus.cnt_clr),
    .inc (w_flush_inc),
    .q   (bus.flush_count)
  );
endmodule
